// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong game sequencer tracking phase, balls left, BCD score and the timer handshake.
// Optional pause/resume support is compiled in when PONG_CTRL_PAUSE_EN is defined.
module pong_game_ctrl #(
  parameter int BALLS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic       hit,
  input  logic       miss,
`ifdef PONG_CTRL_PAUSE_EN
  input  logic       pause,
`endif
  input  logic       timer_up,
  output logic       timer_start,
  output logic       gra_still,
  output logic [2:0] balls_left,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [1:0] text_sel
);

  localparam logic [2:0] BALLS_INIT = 3'(BALLS);

`ifdef PONG_CTRL_PAUSE_EN
  typedef enum logic [2:0] {NEWGAME, PLAY, NEWBALL, OVER, PAUSE} state_t;
`else
  typedef enum logic [2:0] {NEWGAME, PLAY, NEWBALL, OVER} state_t;
`endif

  state_t     state_q, state_d;
  logic       timer_start_q, timer_start_d;
  logic [2:0] balls_q, balls_d;
  logic [3:0] dig0_q, dig0_d;
  logic [3:0] dig1_q, dig1_d;
  logic       score_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= NEWGAME;
      timer_start_q <= 1'b0;
      balls_q       <= BALLS_INIT;
      dig0_q        <= 4'd0;
      dig1_q        <= 4'd0;
    end else begin
      state_q       <= state_d;
      timer_start_q <= timer_start_d;
      balls_q       <= balls_d;
      dig0_q        <= dig0_d;
      dig1_q        <= dig1_d;
    end
  end

  // timer_up is stale during the timer_start cycle, so expiry is only honoured after it
  always_comb begin
    state_d       = state_q;
    timer_start_d = 1'b0;
    balls_d       = balls_q;
    dig0_d        = dig0_q;
    dig1_d        = dig1_q;
    score_inc     = 1'b0;

    case (state_q)
      NEWGAME: begin
        if (btn != 2'b00) begin
          state_d = PLAY;
          balls_d = balls_q - 3'd1;
        end
      end
      PLAY: begin
        score_inc = hit;
`ifdef PONG_CTRL_PAUSE_EN
        if (pause) begin
          state_d = PAUSE;
        end else if (miss && !hit) begin
`else
        if (miss && !hit) begin
`endif
          timer_start_d = 1'b1;
          state_d       = (balls_q == 3'd0) ? OVER : NEWBALL;
        end
      end
      NEWBALL: begin
        if (timer_up && !timer_start_q && (btn != 2'b00)) begin
          state_d = PLAY;
          balls_d = balls_q - 3'd1;
        end
      end
      OVER: begin
        if (timer_up && !timer_start_q) begin
          state_d = NEWGAME;
          balls_d = BALLS_INIT;
          dig0_d  = 4'd0;
          dig1_d  = 4'd0;
        end
      end
`ifdef PONG_CTRL_PAUSE_EN
      PAUSE: begin
        if (pause) begin
          state_d = PLAY;
        end
      end
`endif
      default: begin
        state_d = NEWGAME;
      end
    endcase

    if (score_inc) begin
      if (dig0_q == 4'd9) begin
        dig0_d = 4'd0;
        dig1_d = (dig1_q == 4'd9) ? 4'd0 : dig1_q + 4'd1;
      end else begin
        dig0_d = dig0_q + 4'd1;
      end
    end
  end

  always_comb begin
    gra_still = 1'b1;
    text_sel  = 2'd1;
    case (state_q)
      PLAY: begin
        gra_still = 1'b0;
        text_sel  = 2'd0;
      end
      NEWBALL: text_sel = 2'd2;
      OVER:    text_sel = 2'd3;
      default: text_sel = 2'd1;
    endcase
  end

  assign timer_start = timer_start_q;
  assign balls_left  = balls_q;
  assign dig0        = dig0_q;
  assign dig1        = dig1_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Testbench for pong_game_ctrl: directed game scenarios plus randomized play,
// compared every cycle against a phase/score model of the game rules.
module tb_pong_game_ctrl;

  localparam int BALLS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] btn = 2'b00;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       pause = 1'b0;
  logic       timer_up;
  logic       timer_start;
  logic       gra_still;
  logic [2:0] balls_left;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic [1:0] text_sel;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  pong_game_ctrl #(.BALLS(BALLS)) dut (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .hit(hit),
    .miss(miss),
`ifdef PONG_CTRL_PAUSE_EN
    .pause(pause),
`endif
    .timer_up(timer_up),
    .timer_start(timer_start),
    .gra_still(gra_still),
    .balls_left(balls_left),
    .dig0(dig0),
    .dig1(dig1),
    .text_sel(text_sel)
  );

  always #5 clk = ~clk;

  // Countdown timer standing in for the real timer instance
  int tmr_cnt = 0;
  int tmr_load = 5;
  always @(posedge clk) begin
    if (timer_start) tmr_cnt <= tmr_load;
    else if (tmr_cnt > 0) tmr_cnt <= tmr_cnt - 1;
  end
  assign timer_up = (tmr_cnt == 0);

  // Game model: phase 0=new game, 1=play, 2=new ball, 3=over, 4=paused
  int m_phase = 0;
  int m_score = 0;
  int m_balls = BALLS;
  bit m_ts = 1'b0;

  always @(posedge clk) begin
    bit was_ts;
    bit pause_in;
`ifdef PONG_CTRL_PAUSE_EN
    pause_in = pause;
`else
    pause_in = 1'b0;
`endif
    if (reset) begin
      m_phase = 0; m_score = 0; m_balls = BALLS; m_ts = 1'b0;
    end else begin
      was_ts = m_ts;
      m_ts = 1'b0;
      case (m_phase)
        0: if (btn != 0) begin m_phase = 1; m_balls = m_balls - 1; end
        1: begin
          if (hit) m_score = (m_score + 1) % 100;
          if (pause_in) m_phase = 4;
          else if (miss && !hit) begin
            m_phase = (m_balls == 0) ? 3 : 2;
            m_ts = 1'b1;
          end
        end
        2: if (timer_up && !was_ts && btn != 0) begin m_phase = 1; m_balls = m_balls - 1; end
        3: if (timer_up && !was_ts) begin m_phase = 0; m_score = 0; m_balls = BALLS; end
        4: if (pause_in) m_phase = 1;
        default: m_phase = 0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle the DUT outputs must equal what the model says
  always @(negedge clk) begin
    int exp_text;
    if (check_en) begin
      case (m_phase)
        1: exp_text = 0;
        2: exp_text = 2;
        3: exp_text = 3;
        default: exp_text = 1;
      endcase
      checkOutput("model_gra_still", int'(gra_still), (m_phase == 1) ? 0 : 1);
      checkOutput("model_text_sel", int'(text_sel), exp_text);
      checkOutput("model_timer_start", int'(timer_start), int'(m_ts));
      checkOutput("model_balls_left", int'(balls_left), m_balls);
      checkOutput("model_dig0", int'(dig0), m_score % 10);
      checkOutput("model_dig1", int'(dig1), m_score / 10);
    end
  end

  task automatic applyStimulus(input logic [1:0] b, input logic h, input logic m);
    btn = b; hit = h; miss = m;
    @(negedge clk);
    hit = 1'b0; miss = 1'b0;
  endtask

  task automatic waitTimerUp();
    int n;
    n = 0;
    while (!timer_up && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("timer_up_wait", int'(timer_up), 1);
  endtask

  task automatic checkNewGame(input string tag);
    checkOutput({tag, "_gra_still"}, int'(gra_still), 1);
    checkOutput({tag, "_text_sel"}, int'(text_sel), 1);
    checkOutput({tag, "_balls"}, int'(balls_left), 3);
    checkOutput({tag, "_dig0"}, int'(dig0), 0);
    checkOutput({tag, "_dig1"}, int'(dig1), 0);
    checkOutput({tag, "_timer_start"}, int'(timer_start), 0);
  endtask

  initial begin
    @(negedge clk);
    check_en = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    checkNewGame("reset");
    reset = 1'b0;
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkNewGame("idle");

    applyStimulus(2'b01, 1'b0, 1'b0);
    btn = 2'b00;
    checkOutput("serve_gra_still", int'(gra_still), 0);
    checkOutput("serve_balls", int'(balls_left), 2);

    for (int i = 0; i < 12; i++) applyStimulus(2'b00, 1'b1, 1'b0);
    checkOutput("hit12_dig1", int'(dig1), 1);
    checkOutput("hit12_dig0", int'(dig0), 2);
    for (int i = 0; i < 87; i++) applyStimulus(2'b00, 1'b1, 1'b0);
    checkOutput("hit99_dig1", int'(dig1), 9);
    checkOutput("hit99_dig0", int'(dig0), 9);
    applyStimulus(2'b00, 1'b1, 1'b0);
    checkOutput("wrap_dig1", int'(dig1), 0);
    checkOutput("wrap_dig0", int'(dig0), 0);

    applyStimulus(2'b00, 1'b0, 1'b1);
    checkOutput("miss_text_sel", int'(text_sel), 2);
    checkOutput("miss_timer_start", int'(timer_start), 1);
    applyStimulus(2'b01, 1'b0, 1'b0);
    checkOutput("miss_timer_start_once", int'(timer_start), 0);
    checkOutput("miss_still_newball", int'(text_sel), 2);
    waitTimerUp();
    applyStimulus(2'b01, 1'b0, 1'b0);
    btn = 2'b00;
    checkOutput("reserve_text_sel", int'(text_sel), 0);
    checkOutput("reserve_balls", int'(balls_left), 1);

    applyStimulus(2'b00, 1'b1, 1'b1);
    checkOutput("hitmiss_text_sel", int'(text_sel), 0);
    checkOutput("hitmiss_dig0", int'(dig0), 1);

    applyStimulus(2'b00, 1'b0, 1'b1);
    applyStimulus(2'b10, 1'b0, 1'b0);
    waitTimerUp();
    applyStimulus(2'b10, 1'b0, 1'b0);
    btn = 2'b00;
    checkOutput("last_ball_balls", int'(balls_left), 0);
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 1'b1, 1'b0);
    checkOutput("pre_over_timer_up", int'(timer_up), 1);
    applyStimulus(2'b00, 1'b0, 1'b1);
    checkOutput("over_text_sel", int'(text_sel), 3);
    checkOutput("over_timer_start", int'(timer_start), 1);
    checkOutput("over_dig0", int'(dig0), 4);
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("over_no_early_exit", int'(text_sel), 3);
    waitTimerUp();
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkNewGame("after_over");

    applyStimulus(2'b11, 1'b0, 1'b0);
    btn = 2'b00;
    applyStimulus(2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(2'b00, 1'b0, 1'b0);
    checkOutput("pre_reset_text_sel", int'(text_sel), 2);
    reset = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkNewGame("mid_reset");
    reset = 1'b0;

`ifdef PONG_CTRL_PAUSE_EN
    applyStimulus(2'b01, 1'b0, 1'b0);
    btn = 2'b00;
    applyStimulus(2'b00, 1'b1, 1'b0);
    pause = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0);
    pause = 1'b0;
    applyStimulus(2'b00, 1'b1, 1'b1);
    checkOutput("paused_gra_still", int'(gra_still), 1);
    checkOutput("paused_dig0", int'(dig0), 1);
    pause = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0);
    pause = 1'b0;
    checkOutput("resumed_gra_still", int'(gra_still), 0);
`endif

    for (int i = 0; i < 4000; i++) begin
      tmr_load = $urandom_range(1, 6);
      reset = ($urandom_range(0, 299) == 0);
      pause = ($urandom_range(0, 15) == 0);
      applyStimulus(($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
    end
    reset = 1'b0;
    pause = 1'b0;
    @(negedge clk);
    check_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Top-level game sequencer for Pong. Tracks game phase, remaining balls and a two-digit BCD score. Drives the shared countdown `timer` (start pulse in, `timer_up` back) for the inter-ball and game-over delays. Freezes the graphics datapath between rallies and selects the text overlay. Sits between the button debouncers, the graphics/collision unit and the `timer` instance.

## Interface
- `BALLS`, default 3: balls per game, range 1–7.
- `clk`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high reset.
- `btn`, input, 2: debounced paddle buttons; any nonzero value means "serve/continue".
- `hit`, input, 1: one-cycle pulse from collision logic; the ball was returned by the paddle.
- `miss`, input, 1: one-cycle pulse; the ball passed the paddle.
- `timer_up`, input, 1: from `timer`; high while its count is zero.
- `timer_start`, output, 1: one-cycle pulse; reloads `timer`.
- `gra_still`, output, 1: 1 freezes ball/paddle motion and shows the ball at the serve position.
- `balls_left`, output, 3: balls remaining, not counting the one in play.
- `dig0`, output, 4: score, BCD ones digit.
- `dig1`, output, 4: score, BCD tens digit.
- `text_sel`, output, 2: overlay select. 0 = none, 1 = "press to start", 2 = "ball lost", 3 = "game over".

## Operation
- FSM states: NEWGAME, PLAY, NEWBALL, OVER (plus PAUSE, see Configuration).
- NEWGAME:
  - Outputs: `gra_still=1`, `text_sel=1`; score held at 00; `balls_left=BALLS`.
  - `btn!=0` → PLAY; `balls_left` decrements by 1 on the same edge.
- PLAY:
  - Outputs: `gra_still=0`, `text_sel=0`.
  - `hit` increments the score.
  - `miss` with `balls_left==0` → OVER.
  - `miss` with `balls_left>0` → NEWBALL.
  - Either `miss` transition pulses `timer_start`.
  - `hit` and `miss` in the same cycle: `hit` is taken, `miss` is ignored, state stays PLAY.
- NEWBALL:
  - Outputs: `gra_still=1`, `text_sel=2`.
  - `timer_up=1` and `btn!=0` → PLAY; `balls_left` decrements on that edge.
  - Buttons held before expiry serve immediately on expiry.
- OVER:
  - Outputs: `gra_still=1`, `text_sel=3`.
  - `timer_up=1` → NEWGAME; score is cleared and `balls_left` reloads to BALLS on that edge.
  - Score stays visible throughout OVER.
- Score rules:
  - `dig0` increments; 9 wraps to 0 and carries into `dig1`.
  - 99 + hit → 00. No saturation.
  - Digits never hold a non-BCD value.
- `hit` and `miss` are ignored outside PLAY.
- `balls_left` never underflows; the decrement happens only on the NEWGAME/NEWBALL → PLAY transitions.
- Reset mid-game, in any state, returns everything to reset values on the next edge. `timer_start` is not pulsed.

## Timing
- Reset values: state NEWGAME, `timer_start=0`, `gra_still=1`, `balls_left=BALLS`, `dig0=0`, `dig1=0`, `text_sel=1`.
- All outputs are registered or decoded from registered state only. No combinational path from any input to any output.
- `timer_start`:
  - Goes high for exactly one cycle: the first cycle in NEWBALL or OVER, i.e. one edge after the `miss` is sampled.
  - `timer` reloads on the following edge.
- Stale-expiry guard: `timer_up` is ignored in any cycle where `timer_start=1`. It may still be high from the previous expiry.
- Minimum NEWBALL/OVER dwell is therefore 2 cycles plus the full timer countdown.
- Score update latency: `dig0`/`dig1` change on the edge that samples `hit` and are visible the next cycle.
- State changes on `btn`/`timer_up` take effect one edge after sampling. `gra_still` and `text_sel` follow in the same cycle as the new state.

## Configuration
- Macro `PONG_CTRL_PAUSE_EN`.
- Defined:
  - Adds input `pause` (1 bit, one-cycle pulse) and state PAUSE.
  - PLAY + `pause` → PAUSE. PAUSE + `pause` → PLAY.
  - PAUSE outputs: `gra_still=1`, `text_sel=1`; score and balls are held; `hit`/`miss` are ignored.
  - In PLAY, `pause` has priority over `miss`; it is lower than `hit` for the score update only.
  - `pause` outside PLAY/PAUSE is ignored.
- Undefined: no `pause` port, no PAUSE state; behaviour is exactly as above.

## Test plan
- Reset, hold 5 cycles, release:
  - Outputs are NEWGAME values, `balls_left=3`, score 00, `timer_start` never high.
  - `btn=2'b01` for 1 cycle → `gra_still=0`, `balls_left=2` the next cycle.
- In PLAY, pulse `hit` 12 times:
  - `dig1=1`, `dig0=2`.
  - Preload to 99, then one `hit` → 00.
- In PLAY with `balls_left=2`, pulse `miss`:
  - NEWBALL, `timer_start` high for exactly 1 cycle, `text_sel=2`.
  - Hold `btn` during the countdown → PLAY one edge after `timer_up` rises, `balls_left=1`.
- Miss with `balls_left=0`:
  - OVER, `timer_start` pulsed, score still shown.
  - After `timer_up` → NEWGAME, score 00, `balls_left=3`.
  - Drive `timer_up=1` already high at the miss: no early exit.
- `hit` and `miss` in the same cycle → score +1, state stays PLAY.
- Assert `reset` mid-countdown in NEWBALL:
  - NEWGAME values on the next edge.
  - With `PONG_CTRL_PAUSE_EN`: pause/resume in PLAY freezes the score and `gra_still=1` while paused.
